rv_pipe_stage: RTL and testbench
================================

# rv_pipe_stage

Parametrised elastic pipeline register for the core datapath. It carries `DATA_WIDTH`-bit payloads through `STAGES` registered stages using a valid/ready handshake. A one-entry input skid buffer keeps `in_ready` fully registered. A synchronous flush clears all in-flight beats. It replaces hand-chained enable/clear registers between pipeline boundaries, adding per-stage valid tracking, back-pressure and bubble collapsing.

## Interface
- `DATA_WIDTH`, 32: payload width in bits (≥1).
- `STAGES`, 2: number of payload register stages (1..8).
- `CLR_DATA`, 1: 1 = flush also zeroes all data registers; 0 = flush clears valid bits only.

Ports:
- `clk` — input, 1: single clock; all state updates on its rising edge.
- `rstn` — input, 1: asynchronous, active-low reset.
- `flush` — input, 1: synchronous clear of all in-flight beats; priority over all other activity.
- `in_valid` — input, 1: upstream beat present.
- `in_ready` — output, 1: block can accept a beat; driven directly from a register.
- `in_data` — input, `DATA_WIDTH`: upstream payload.
- `out_valid` — output, 1: valid bit of the last stage.
- `out_ready` — input, 1: downstream accepts.
- `out_data` — output, `DATA_WIDTH`: payload of the last stage.
- `occupancy` — output, `$clog2(STAGES+2)`: number of valid entries (stages + skid), 0..`STAGES`+1.

## Operation
- State:
  - Stage registers `v[i]`/`d[i]`, i = 0..`STAGES`-1; stage `STAGES`-1 drives the outputs.
  - Skid register `sv`/`sd`.
- Reset (`rstn`=0, asynchronous): all `v`=0, `sv`=0, all `d`/`sd`=0.
  - Outputs during and after reset: `out_valid`=0, `out_data`=0, `occupancy`=0, `in_ready`=1.
  - No beat is captured while `rstn`=0.
- Per-stage advance (combinational chain):
  - `rdy[STAGES]` = `out_ready`.
  - `rdy[i]` = !`v[i]` || `rdy[i+1]`.
  - When `rdy[i+1]`, stage i+1 loads `v[i]`/`d[i]`.
  - A bubble (`v[i]`=0) is overwritten, so gaps collapse under back-pressure.
- Input path:
  - `in_ready` = !`sv`. An input handshake is `in_valid` && `in_ready`.
  - If `sv`=1 and `rdy[0]`: stage 0 loads `sd`, then `sv`←0.
  - If `sv`=0, a handshake occurs and `rdy[0]`=1: stage 0 loads `in_data` directly.
  - If `sv`=0, a handshake occurs and `rdy[0]`=0: `sv`←1, `sd`←`in_data`.
  - Stage 0 otherwise loads `v[0]`←0 when `rdy[0]`.
- Ordering: strict FIFO. The skid beat is always older than any later input.
- Output: a handshake (`out_valid` && `out_ready`) retires the last stage's beat in that cycle.
- Flush (`flush`=1 at an edge, `rstn`=1):
  - All `v`←0 and `sv`←0.
  - If `CLR_DATA`=1, all `d`/`sd`←0; otherwise data registers hold their values.
  - Any input handshake in the flush cycle is discarded.
  - An output handshake in the flush cycle still counts as consumed downstream.
- Occupancy: registered. It equals popcount(`v`) + `sv` after each edge.
- Capacity is `STAGES`+1 beats. When full, `in_ready`=0 until the skid drains.
- `out_data` is undefined-but-stable when `out_valid`=0 (zero after reset or a `CLR_DATA` flush).

## Timing
- Latency: a beat accepted at edge t into an empty pipe shows `out_valid`=1 after edge t+`STAGES`-1.
  - `STAGES`=1: visible in the cycle right after acceptance.
  - General case: the beat is registered `STAGES` times before reaching the outputs.
- Throughput: 1 beat/cycle sustained while `out_ready`=1.
- `in_ready` deasserts one cycle after the first stall-induced skid capture and reasserts the cycle after the skid drains.
- Only `out_ready`→stage-load logic is combinational. There is no combinational path from `out_ready` to `in_ready`.
- Flush takes effect at the edge where it is sampled:
  - Next cycle: `out_valid`=0, `occupancy`=0, `in_ready`=1.
  - Flush held for multiple cycles keeps the pipe empty.
- Reset mid-stream: all beats are lost immediately (asynchronously). Outputs are at reset values before the next edge.

## Test plan
- Single beat, `STAGES`=2, `out_ready`=1: `in_data`=0xDEADBEEF accepted at edge 0 → `out_valid`=1 with 0xDEADBEEF after edge 1, for exactly one cycle. `occupancy` reads 1 then 0.
- Streaming: 16 consecutive beats 0..15, `out_ready`=1 → outputs 0..15 on consecutive cycles, `in_ready` stays 1, no gaps.
- Back-pressure fill, `STAGES`=2: `out_ready`=0, push 0xA,0xB,0xC → `occupancy`=3 and `in_ready`=0. Release `out_ready` → 0xA,0xB,0xC in order, and `in_ready`=1 the cycle after the skid empties.
- Bubble collapse: one beat, idle 2 cycles, second beat, `out_ready`=0 → both stages valid, `occupancy`=2, no bubble at the outputs once released.
- Flush with 3 beats in flight and `in_valid`=1 with 0x55 in the flush cycle → next cycle `out_valid`=0, `occupancy`=0, `in_ready`=1, and 0x55 never appears. With `CLR_DATA`=1, `out_data`=0.
- Reset mid-stream: drop `rstn` asynchronously between edges with 2 beats held → `out_valid`, `occupancy` and `out_data` go to 0 immediately. After release, a new beat 0x1 emerges with normal latency.

Source files
------------

// File: rtl/rv_pipe_stage.sv
// ---------------------------------------------------------------------------
// rv_pipe_stage
//
// Elastic pipeline register: carries DATA_WIDTH-bit beats through STAGES
// registered stages with a valid/ready handshake. A one-entry skid buffer in
// front of stage 0 absorbs the beat that arrives while the pipe is stalled,
// so in_ready comes straight from a flop and never depends combinationally
// on out_ready. Bubbles between beats are squeezed out under back-pressure.
//
// Parameters:
//   DATA_WIDTH - payload width in bits (>= 1)
//   STAGES     - number of payload register stages (1..8)
//   CLR_DATA   - 1: flush also zeroes data registers; 0: flush clears valids
//
// Ports:
//   clk        - clock, all state changes on its rising edge
//   rstn       - asynchronous active-low reset
//   flush      - synchronous clear of all in-flight beats (highest priority)
//   in_valid   - upstream beat present
//   in_ready   - block can take a beat (registered)
//   in_data    - upstream payload
//   out_valid  - last stage holds a beat
//   out_ready  - downstream accepts
//   out_data   - last stage payload
//   occupancy  - registered count of valid entries (stages + skid)
// ---------------------------------------------------------------------------
module rv_pipe_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 2,
    parameter bit CLR_DATA   = 1'b1,
    localparam int OCC_W     = $clog2(STAGES + 2)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [OCC_W-1:0]      occupancy
);

    // Stage registers; index STAGES-1 drives the outputs.
    logic [STAGES-1:0]     v_q;
    logic [DATA_WIDTH-1:0] d_q [STAGES];
    // Skid entry.
    logic                  sv_q;
    logic [DATA_WIDTH-1:0] sd_q;
    logic                  in_ready_q;
    logic [OCC_W-1:0]      occ_q;

    // Next-state values.
    logic [STAGES-1:0]     v_nxt;
    logic [DATA_WIDTH-1:0] d_nxt [STAGES];
    logic                  sv_nxt;
    logic [DATA_WIDTH-1:0] sd_nxt;
    logic [OCC_W-1:0]      occ_nxt;

    // rdy[i]: stage i may load this cycle; rdy[STAGES] is the downstream port.
    logic [STAGES:0]       rdy;
    logic                  take;

    always_comb begin : next_state
        // NOTE: every variable gets a default before any conditional update,
        // otherwise paths that skip an assignment infer latches.
        v_nxt  = v_q;
        sv_nxt = sv_q;
        sd_nxt = sd_q;
        for (int i = 0; i < STAGES; i++) begin
            d_nxt[i] = d_q[i];
        end
        occ_nxt = '0;

        // NOTE: blocking assignments here model combinational intent; each
        // rdy bit reads the one above it computed earlier in this same pass.
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            rdy[i] = ~v_q[i] | rdy[i+1];
        end

        // Stages 1..STAGES-1 pull from the stage behind them whenever free or
        // draining; a bubble is simply copied forward and then overwritten.
        for (int i = 1; i < STAGES; i++) begin
            if (rdy[i]) begin
                v_nxt[i] = v_q[i-1];
                d_nxt[i] = d_q[i-1];
            end
        end

        // Input handshake; in_ready is exactly !sv.
        take = in_valid & ~sv_q;

        if (rdy[0]) begin
            if (sv_q) begin
                // The skid beat is older than anything arriving now.
                v_nxt[0] = 1'b1;
                d_nxt[0] = sd_q;
                sv_nxt   = 1'b0;
            end else if (take) begin
                v_nxt[0] = 1'b1;
                d_nxt[0] = in_data;
            end else begin
                v_nxt[0] = 1'b0;
            end
        end else if (take) begin
            // Pipe stalled: park the accepted beat in the skid.
            sv_nxt = 1'b1;
            sd_nxt = in_data;
        end

        // Flush overrides everything above, including any accepted input.
        if (flush) begin
            v_nxt  = '0;
            sv_nxt = 1'b0;
            if (CLR_DATA) begin
                for (int i = 0; i < STAGES; i++) begin
                    d_nxt[i] = '0;
                end
                sd_nxt = '0;
            end
        end

        for (int i = 0; i < STAGES; i++) begin
            occ_nxt = occ_nxt + OCC_W'(v_nxt[i]);
        end
        occ_nxt = occ_nxt + OCC_W'(sv_nxt);
    end

    // NOTE: the data registers are reset along with the valids because
    // out_data must read zero after reset; a pure datapath could skip this.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_q        <= '0;
            sv_q       <= 1'b0;
            sd_q       <= '0;
            in_ready_q <= 1'b1;
            occ_q      <= '0;
            for (int i = 0; i < STAGES; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q        <= v_nxt;
            sv_q       <= sv_nxt;
            sd_q       <= sd_nxt;
            in_ready_q <= ~sv_nxt;
            occ_q      <= occ_nxt;
            for (int i = 0; i < STAGES; i++) begin
                d_q[i] <= d_nxt[i];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = v_q[STAGES-1];
    assign out_data  = d_q[STAGES-1];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_rv_pipe_stage.sv
// ---------------------------------------------------------------------------
// tb_rv_pipe_stage
//
// Scoreboard bench for rv_pipe_stage. The reference model is a plain FIFO of
// accepted payloads: capacity STAGES+1, occupancy = entries held, in_ready =
// not full, output order = acceptance order. The driver pushes accepted
// beats; an independent monitor pops and compares on each output handshake.
// ---------------------------------------------------------------------------
module tb_rv_pipe_stage;

    localparam int S     = 2;
    localparam int DW    = 32;
    localparam int OCC_W = $clog2(S + 2);

    logic             clk;
    logic             rstn;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [OCC_W-1:0] occupancy;

    rv_pipe_stage #(
        .DATA_WIDTH (DW),
        .STAGES     (S),
        .CLR_DATA   (1'b1)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    logic [DW-1:0] exp_q[$];
    int            pop_cyc_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle of stimulus; inputs change 1 time unit after posedge.
    task automatic drive(input logic iv, input logic [DW-1:0] id,
                         input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        #1;
        if (rstn && in_valid && in_ready && !flush) exp_q.push_back(in_data);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int k = 0; k < n; k++) drive(1'b0, '0, ordy, 1'b0);
    endtask

    // Single beat into an empty pipe: visible after STAGES-1 further edges,
    // for exactly one cycle.
    task automatic latency_beat(input logic [DW-1:0] val, input string tag);
        drive(1'b1, val, 1'b1, 1'b0);
        check({tag, "_occ_after_accept"}, occupancy, 1);
        for (int k = 0; k < S - 1; k++) begin
            check({tag, "_not_early"}, out_valid, 0);
            drive(1'b0, '0, 1'b1, 1'b0);
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, val);
        drive(1'b0, '0, 1'b1, 1'b0);
        check({tag, "_one_cycle"}, out_valid, 0);
        check({tag, "_occ_empty"}, occupancy, 0);
    endtask

    // Monitor: compares registered state with the model at every negedge and
    // retires the model head on each output handshake.
    initial begin
        forever begin
            @(negedge clk);
            check("mon_occupancy", occupancy, exp_q.size());
            check("mon_in_ready", in_ready, exp_q.size() != S + 1);
            if (rstn && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_unexpected_beat: got %0h expected no beat (cycle %0d)",
                             out_data, cyc);
                end else begin
                    check("mon_out_data", out_data, exp_q.pop_front());
                end
                pop_cyc_q.push_back(cyc);
            end
            if (rstn && flush) exp_q.delete();
        end
    end

    initial begin
        rstn      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Single beat latency.
        latency_beat(32'hDEADBEEF, "single");

        // Streaming 0..15 with out_ready held high: no gaps.
        pop_cyc_q.delete();
        for (int i = 0; i < 16; i++) drive(1'b1, DW'(i), 1'b1, 1'b0);
        idle(S + 1, 1'b1);
        check("stream_count", pop_cyc_q.size(), 16);
        if (pop_cyc_q.size() == 16)
            check("stream_no_gaps", pop_cyc_q[15] - pop_cyc_q[0], 15);

        // Back-pressure fill to capacity, then release.
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        drive(1'b1, 32'hC, 1'b0, 1'b0);
        check("bp_occ_full", occupancy, 3);
        check("bp_in_ready_low", in_ready, 0);
        drive(1'b1, 32'hD, 1'b0, 1'b0);
        check("bp_still_full", occupancy, 3);
        drive(1'b0, '0, 1'b1, 1'b0);
        check("bp_in_ready_back", in_ready, 1);
        check("bp_occ_after_release", occupancy, 2);
        idle(S + 1, 1'b1);

        // Bubble collapse under back-pressure.
        drive(1'b1, 32'h111, 1'b0, 1'b0);
        idle(2, 1'b0);
        drive(1'b1, 32'h222, 1'b0, 1'b0);
        check("bubble_occ", occupancy, 2);
        check("bubble_out_valid", out_valid, 1);
        pop_cyc_q.delete();
        idle(S + 1, 1'b1);
        check("bubble_count", pop_cyc_q.size(), 2);
        if (pop_cyc_q.size() == 2)
            check("bubble_back_to_back", pop_cyc_q[1] - pop_cyc_q[0], 1);

        // Flush with a full pipe and an offered beat.
        drive(1'b1, 32'h1, 1'b0, 1'b0);
        drive(1'b1, 32'h2, 1'b0, 1'b0);
        drive(1'b1, 32'h3, 1'b0, 1'b0);
        drive(1'b1, 32'h55, 1'b0, 1'b1);
        check("flush_out_valid", out_valid, 0);
        check("flush_occ", occupancy, 0);
        check("flush_in_ready", in_ready, 1);
        check("flush_out_data_zero", out_data, 0);
        pop_cyc_q.delete();
        idle(S + 2, 1'b1);
        check("flush_nothing_left", pop_cyc_q.size(), 0);

        // Flush with an accepted input and an output handshake in the same cycle.
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        drive(1'b1, 32'h20, 1'b0, 1'b0);
        pop_cyc_q.delete();
        drive(1'b1, 32'h55, 1'b1, 1'b1);
        check("flush2_retired_one", pop_cyc_q.size(), 1);
        check("flush2_occ", occupancy, 0);
        idle(S + 2, 1'b1);
        check("flush2_nothing_left", pop_cyc_q.size(), 1);

        // Flush held several cycles keeps the pipe empty.
        for (int k = 0; k < 3; k++) drive(1'b1, 32'h77, 1'b1, 1'b1);
        check("flush_held_occ", occupancy, 0);
        check("flush_held_valid", out_valid, 0);

        // Reset mid-stream, asserted between edges.
        drive(1'b1, 32'hAA, 1'b0, 1'b0);
        drive(1'b1, 32'hBB, 1'b0, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_occ", occupancy, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_in_ready", in_ready, 1);
        in_valid  = 1'b1;
        in_data   = 32'h99;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_no_capture", occupancy, 0);
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        latency_beat(32'h1, "post_rst");

        // Randomized traffic with occasional flushes.
        for (int k = 0; k < 1500; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
        end
        idle(S + 3, 1'b1);
        check("final_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
